// File: rtl/wb_dbg_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : wb_dbg_master
//  Purpose  : Byte-stream driven Wishbone initiator for host debug / firmware
//             load. Parses WRITE (0x01) and READ (0x02) frames from the rx
//             stream, runs one classic Wishbone cycle and returns a status
//             byte (plus read data, MSB first) on the tx stream.
//  Options  : WB_DBG_TIMEOUT_EN - abort a bus cycle after TIMEOUT_CYCLES
//             cycles without ack and answer 0xEE.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_dbg_master #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_BUS  = 3'd3,
      S_RESP = 3'd4
   } state_t;

   localparam logic [7:0] CMD_WRITE  = 8'h01;
   localparam logic [7:0] CMD_READ   = 8'h02;
   localparam logic [7:0] ST_OK      = 8'hA5;
   localparam logic [7:0] ST_BADCMD  = 8'hE1;
   localparam logic [7:0] ST_TIMEOUT = 8'hEE;

   // The timeout counter must be able to reach TIMEOUT_CYCLES.
   generate
      if ((2 ** TO_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
         $error("wb_dbg_master: TO_W too small for TIMEOUT_CYCLES");
      end
   endgenerate

   state_t      state_q, state_d;
   logic        wr_q, wr_d;         // latched opcode: 1 = WRITE, 0 = READ
   logic [1:0]  cnt_q, cnt_d;       // byte index within a 4-byte field
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [31:0] rd_q, rd_d;         // read data, shifted out MSB first
   logic [7:0]  tx_q, tx_d;         // byte currently presented on tx
   logic [2:0]  rem_q, rem_d;       // response bytes still to follow tx_q
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
`ifdef WB_DBG_TIMEOUT_EN
   logic [TO_W-1:0] to_q, to_d;
`endif

   logic rx_fire;
   logic tx_fire;

   assign rx_ready = !rst && ((state_q == S_IDLE) || (state_q == S_ADDR) ||
                              (state_q == S_DATA));
   assign rx_fire  = rx_valid && rx_ready;
   assign tx_valid = (state_q == S_RESP);
   assign tx_fire  = tx_valid && tx_ready;
   assign tx_data  = tx_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel_o = 4'hF;
   assign wb_we_o  = we_q;
   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign busy     = (state_q != S_IDLE);

   // Next-state logic: frame parsing, bus handshake and response sequencing.
   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      rd_d    = rd_q;
      tx_d    = tx_q;
      rem_d   = rem_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
`ifdef WB_DBG_TIMEOUT_EN
      to_d    = to_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (rx_fire) begin
               if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
                  wr_d    = (rx_data == CMD_WRITE);
                  cnt_d   = 2'd0;
                  state_d = S_ADDR;
               end else begin
                  tx_d    = ST_BADCMD;
                  rem_d   = 3'd0;
                  state_d = S_RESP;
               end
            end
         end
         S_ADDR: begin
            if (rx_fire) begin
               adr_d = {adr_q[23:0], rx_data};
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  if (wr_q) begin
                     state_d = S_DATA;
                  end else begin
                     cyc_d   = 1'b1;
                     we_d    = 1'b0;
`ifdef WB_DBG_TIMEOUT_EN
                     to_d    = '0;
`endif
                     state_d = S_BUS;
                  end
               end
            end
         end
         S_DATA: begin
            if (rx_fire) begin
               dat_d = {dat_q[23:0], rx_data};
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  cyc_d   = 1'b1;
                  we_d    = 1'b1;
`ifdef WB_DBG_TIMEOUT_EN
                  to_d    = '0;
`endif
                  state_d = S_BUS;
               end
            end
         end
         S_BUS: begin
            // Ack takes priority over a timeout in the same cycle.
            if (wb_ack_i) begin
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               tx_d    = ST_OK;
               if (wr_q) begin
                  rem_d = 3'd0;
               end else begin
                  rd_d  = wb_dat_i;
                  rem_d = 3'd4;
               end
               state_d = S_RESP;
`ifdef WB_DBG_TIMEOUT_EN
            end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               tx_d    = ST_TIMEOUT;
               rem_d   = 3'd0;
               state_d = S_RESP;
            end else begin
               to_d = to_q + 1'b1;
`endif
            end
         end
         S_RESP: begin
            if (tx_fire) begin
               if (rem_q == 3'd0) begin
                  tx_d    = 8'h00;
                  state_d = S_IDLE;
               end else begin
                  tx_d  = rd_q[31:24];
                  rd_d  = {rd_q[23:0], 8'h00};
                  rem_d = rem_q - 3'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cyc_d   = 1'b0;
            we_d    = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         cnt_q   <= 2'd0;
         adr_q   <= 32'h0;
         dat_q   <= 32'h0;
         rd_q    <= 32'h0;
         tx_q    <= 8'h00;
         rem_q   <= 3'd0;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
`ifdef WB_DBG_TIMEOUT_EN
         to_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         rd_q    <= rd_d;
         tx_q    <= tx_d;
         rem_q   <= rem_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
`ifdef WB_DBG_TIMEOUT_EN
         to_q    <= to_d;
`endif
      end
   end

endmodule
`default_nettype wire
